// File: rtl/fetch_stage.sv
//==============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage. Owns the PC, issues single-outstanding
//            word fetches to a variable-latency instruction memory and fills
//            the IF/ID pipeline register. Handles hazard stalls and EX
//            redirects (branch taken / jump).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);

  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_discard;
  logic        w_discard_nxt;
  logic [31:0] r_hold_inst;
  logic [31:0] w_hold_inst_nxt;

  logic [31:0] w_pc4;
  logic [31:0] w_redirect_pc;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_load;
  logic [31:0] w_load_inst;

  assign w_pc4         = r_pc + 32'd4;
  assign w_redirect_pc = redirect_pc & c_ALIGN_MASK;

  // The request is suppressed while reset is held so the first pulse lands in
  // the first cycle after release; the address is always forced word aligned.
  assign imem_req  = w_req & rst_n;
  assign imem_addr = w_addr & c_ALIGN_MASK;

  // Next-state, next-PC and request generation for the ISSUE/WAIT/HOLD machine.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_discard_nxt   = r_discard;
    w_hold_inst_nxt = r_hold_inst;
    w_req           = 1'b0;
    w_addr          = r_pc;
    w_load          = 1'b0;
    w_load_inst     = imem_rdata;

    case (r_state)
      S_ISSUE: begin
        // The request goes out even when redirected; its response is then
        // marked stale and dropped on return.
        w_req       = 1'b1;
        w_addr      = r_pc;
        w_state_nxt = S_WAIT;
        if (redirect) begin
          w_pc_nxt      = w_redirect_pc;
          w_discard_nxt = 1'b1;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          w_pc_nxt = w_redirect_pc;
          if (imem_rvalid) begin
            // Response in the redirect cycle is dropped; nothing in flight.
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_ISSUE;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_ISSUE;
          end else if (stall) begin
            // The hold buffer pairs this data with r_pc, which stays put
            // until the buffer drains.
            w_hold_inst_nxt = imem_rdata;
            w_state_nxt     = S_HOLD;
          end else begin
            // Fast path: deliver and immediately request the next word.
            w_load   = 1'b1;
            w_pc_nxt = w_pc4;
            w_req    = 1'b1;
            w_addr   = w_pc4;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          // Leaving HOLD abandons the buffered instruction.
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = S_ISSUE;
        end else if (!stall) begin
          w_load      = 1'b1;
          w_load_inst = r_hold_inst;
          w_pc_nxt    = w_pc4;
          w_state_nxt = S_ISSUE;
        end
      end

      default: begin
        w_state_nxt = S_ISSUE;
      end
    endcase
  end

  // Control state: FSM state, PC, stale-response flag and hold buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ISSUE;
      r_pc        <= RESET_PC & c_ALIGN_MASK;
      r_discard   <= 1'b0;
      r_hold_inst <= NOP_INST;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_discard   <= w_discard_nxt;
      r_hold_inst <= w_hold_inst_nxt;
    end
  end

  // IF/ID register: flush beats stall, stall holds, otherwise load or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end else if (!stall) begin
      if (w_load) begin
        if_id_valid <= 1'b1;
        if_id_inst  <= w_load_inst;
        if_id_pc    <= r_pc;
        if_id_pc4   <= w_pc4;
      end else begin
        if_id_valid <= 1'b0;
        if_id_inst  <= NOP_INST;
      end
    end
  end

`ifndef SYNTHESIS
  // A response is only legal while a request is outstanding.
  a_rvalid_in_wait : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (r_state == S_WAIT));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//==============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed cycle table,
//            async-reset and PC-wrap sequences, and a randomized run checked
//            against a program-order reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NV  = 19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  // Second instance for the PC wrap-around case.
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_rdata = 32'h0;
  logic        wr_rvalid = 1'b0;
  logic [31:0] wr_pc;
  logic [31:0] wr_pc4;
  logic [31:0] wr_inst;
  logic        wr_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model state.
  logic        mem_busy = 1'b0;
  logic [2:0]  mem_cnt  = 3'd0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_lat  = 1;
  bit          mem_rand = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_inst(if_id_inst),
    .if_id_valid(if_id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(NOP)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(wr_req), .imem_addr(wr_addr),
    .imem_rdata(wr_rdata), .imem_rvalid(wr_rvalid),
    .if_id_pc(wr_pc), .if_id_pc4(wr_pc4), .if_id_inst(wr_inst),
    .if_id_valid(wr_valid)
  );

  // Address-tagged instruction contents.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // Main memory: one request at a time, response after the chosen latency.
  assign imem_rvalid = mem_busy && (mem_cnt == 3'd0);
  assign imem_rdata  = imem_rvalid ? tag(mem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_busy) begin
      if (mem_cnt == 3'd0) mem_busy <= 1'b0;
      else                 mem_cnt  <= mem_cnt - 3'd1;
    end
    if (rst_n && imem_req) begin
      chk("one_outstanding", 32'(mem_busy && (mem_cnt != 3'd0)), 32'h0);
      mem_busy <= 1'b1;
      mem_addr <= imem_addr;
      mem_cnt  <= mem_rand ? 3'($urandom_range(0, 3)) : 3'(mem_lat - 1);
    end
  end

  // Wrap instance memory: fixed 1-cycle latency.
  always @(posedge clk) begin
    wr_rvalid <= rst_n && wr_req;
    wr_rdata  <= tag(wr_addr);
  end

  typedef struct {
    int          lat;
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tv [NV];

  function automatic vec_t mk(input int lat, input bit st, input bit rd,
                              input logic [31:0] rpc, input bit rq,
                              input logic [31:0] ad, input bit v,
                              input logic [31:0] pc);
    vec_t t;
    t.lat = lat; t.stall = st; t.redir = rd; t.rpc = rpc;
    t.req = rq; t.addr = ad; t.valid = v; t.pc = pc;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] wexp;
    logic [31:0] p_pc;
    logic [31:0] p_inst;
    bit          p_valid;
    bit          p_stall;
    bit          p_redir;
    int          delivered;

    // lat, stall, redirect, redirect_pc | req, addr, valid, pc
    tv[0]  = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000);
    tv[1]  = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000);
    tv[2]  = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000);
    tv[3]  = mk(1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h004);
    tv[4]  = mk(1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h004);
    tv[5]  = mk(1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h004);
    tv[6]  = mk(1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h004);
    tv[7]  = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h008);
    tv[8]  = mk(3, 1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b0, 32'h000);
    tv[9]  = mk(3, 1'b0, 1'b1, 32'h100, 1'b0, 32'h000, 1'b1, 32'h00C);
    tv[10] = mk(1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000);
    tv[11] = mk(1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000);
    tv[12] = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000);
    tv[13] = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000);
    tv[14] = mk(1, 1'b1, 1'b1, 32'h203, 1'b0, 32'h000, 1'b1, 32'h100);
    tv[15] = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000);
    tv[16] = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h000);
    tv[17] = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200);
    tv[18] = mk(1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h20C, 1'b1, 32'h204);

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(imem_req),    32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_inst",  if_id_inst,       NOP);
    chk("rst_pc",    if_id_pc,         32'h0);
    chk("rst_pc4",   if_id_pc4,        32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cycle table, with the wrap instance checked alongside.
    for (int i = 0; i < NV; i++) begin
      mem_lat     = tv[i].lat;
      stall       = tv[i].stall;
      redirect    = tv[i].redir;
      redirect_pc = tv[i].rpc;
      @(negedge clk);
      chk($sformatf("tv%0d_req", i), 32'(imem_req), 32'(tv[i].req));
      if (tv[i].req) chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), 32'(if_id_valid), 32'(tv[i].valid));
      if (tv[i].valid) begin
        chk($sformatf("tv%0d_pc", i),   if_id_pc,   tv[i].pc);
        chk($sformatf("tv%0d_pc4", i),  if_id_pc4,  tv[i].pc + 32'd4);
        chk($sformatf("tv%0d_inst", i), if_id_inst, tag(tv[i].pc));
      end else begin
        chk($sformatf("tv%0d_nop", i), if_id_inst, NOP);
      end
      if (i < 3) begin
        wexp = 32'hFFFF_FFF8 + 32'(4 * i);
        chk($sformatf("wrap%0d_req", i),  32'(wr_req), 32'h1);
        chk($sformatf("wrap%0d_addr", i), wr_addr,     wexp);
      end else if (i == 3) begin
        chk("wrap_pc",   wr_pc,   32'hFFFF_FFFC);
        chk("wrap_pc4",  wr_pc4,  32'h0);
        chk("wrap_inst", wr_inst, tag(32'hFFFF_FFFC));
      end
      @(posedge clk); #1;
    end
    stall    = 1'b0;
    redirect = 1'b0;

    // Async reset while a 3-cycle request is outstanding.
    mem_lat = 3;
    @(negedge clk);
    chk("pre_reset_req",  32'(imem_req), 32'h1);
    chk("pre_reset_addr", imem_addr,     32'h210);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_req",   32'(imem_req),    32'h0);
    chk("async_valid", 32'(if_id_valid), 32'h0);
    chk("async_inst",  if_id_inst,       NOP);
    chk("async_pc",    if_id_pc,         32'h0);
    repeat (6) @(posedge clk);
    #1;
    mem_lat = 1;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("post_reset_req",  32'(imem_req), 32'h1);
    chk("post_reset_addr", imem_addr,     32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post_reset_valid", 32'(if_id_valid), 32'h1);
    chk("post_reset_pc",    if_id_pc,         32'h0);
    chk("post_reset_inst",  if_id_inst,       tag(32'h0));

    // Randomized run against a program-order model: every instruction decode
    // consumes must be the successor of the previous one or a redirect target.
    @(posedge clk); #2;
    rst_n = 1'b0;
    mem_rand = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_pc    = 32'h0;
    delivered = 0;
    p_stall   = 1'b0;
    p_redir   = 1'b0;
    p_valid   = 1'b0;
    p_pc      = 32'h0;
    p_inst    = NOP;
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 15) == 0) ? 32'($urandom) : {20'h0, 12'($urandom)};
      @(negedge clk);
      if (if_id_valid) begin
        chk("rnd_inst", if_id_inst, tag(if_id_pc));
        chk("rnd_pc4",  if_id_pc4,  if_id_pc + 32'd4);
      end
      if (p_redir) begin
        chk("rnd_flush", 32'(if_id_valid), 32'h0);
      end else if (p_stall) begin
        chk("rnd_hold_valid", 32'(if_id_valid), 32'(p_valid));
        chk("rnd_hold_pc",    if_id_pc,         p_pc);
        chk("rnd_hold_inst",  if_id_inst,       p_inst);
      end
      if (imem_req) chk("rnd_align", 32'(imem_addr[1:0]), 32'h0);
      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (!stall && if_id_valid) begin
        chk("rnd_order", if_id_pc, exp_pc);
        exp_pc = if_id_pc + 32'd4;
        delivered++;
      end
      p_stall = stall;
      p_redir = redirect;
      p_valid = if_id_valid;
      p_pc    = if_id_pc;
      p_inst  = if_id_inst;
      @(posedge clk); #1;
    end
    stall    = 1'b0;
    redirect = 1'b0;
    chk("rnd_progress", 32'(delivered >= 200), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register and issues word fetches to instruction memory, which has variable latency and allows one outstanding request.
- Presents the fetched instruction through the IF/ID pipeline register to decode, where the immediate generator and control unit consume it.
- Handles hazard-unit stalls, and branch/jump redirects from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- NOP_INST, 32'h0000_0013, instruction driven on if_id_inst when the stage holds a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: IF/ID must hold its contents.
- redirect  in  1  EX: branch taken or jump; refetch from redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0 internally.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_addr  out  32  fetch address, word aligned; valid when imem_req=1.
- imem_rdata  in  32  instruction returned by memory.
- imem_rvalid  in  1  response strobe; arrives 1 or more cycles after imem_req.
- if_id_pc  out  32  PC of the instruction in IF/ID.
- if_id_pc4  out  32  if_id_pc + 4.
- if_id_inst  out  32  instruction to decode.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=ISSUE, discard=0, if_id_valid=0, if_id_inst=NOP_INST, if_id_pc=0, if_id_pc4=0, imem_req=0. The first request goes out in the first cycle after reset release.
- imem_req and imem_addr are combinational from state and inputs. imem_addr is always 4-byte aligned.

State machine (ISSUE, WAIT, HOLD):
- ISSUE:
  - Drive imem_req=1 with imem_addr=pc, then go to WAIT.
  - If redirect is also high: pc<=redirect_pc, discard<=1, go to WAIT. The stale request is still issued.
- WAIT:
  - Responses are accepted only in WAIT.
  - Case A, rvalid=1 and discard=1: drop the data, clear discard, go to ISSUE.
  - Case B, rvalid=1, discard=0, stall=0, redirect=0:
    - Load IF/ID with pc, pc+4, rdata, and valid=1.
    - pc<=pc+4.
    - Fast path: in the same cycle drive imem_req=1 with imem_addr=pc+4, and stay in WAIT.
  - Case C, rvalid=1, discard=0, stall=1, redirect=0: capture rdata and pc into the hold buffer, go to HOLD.
  - With a 1-cycle-latency memory and no stalls, the fast path sustains 1 instruction/cycle after the first fetch.
- HOLD:
  - When stall=0: load IF/ID from the hold buffer, pc<=pc+4, go to ISSUE.
  - While stall=1: stay in HOLD.

Stall and redirect:
- While stall=1, all IF/ID outputs hold. No request issues from HOLD.
- Redirect has priority over stall and over any response in the same cycle. On redirect:
  - if_id_valid<=0, if_id_inst<=NOP_INST, pc<=redirect_pc.
  - Hold buffer is invalidated.
  - If a request is outstanding (WAIT with no rvalid this cycle, or ISSUE/fast path issuing this cycle), set discard<=1 and remain in or enter WAIT.
  - A WAIT-state response arriving in the redirect cycle is dropped. If no other request is outstanding, go to ISSUE.
- Redirect and stall together: the flush wins. IF/ID becomes a bubble.

Boundary conditions:
- rvalid outside WAIT is a protocol error. It is ignored, with an assertion in simulation.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-WAIT abandons the request. Any later rvalid arrives outside WAIT and is ignored.
- Only one outstanding request at any time: imem_req never fires again until rvalid has been received for the previous one.

Test Plan:
- Reset, 1-cycle memory returning addr-tagged data, no stalls: requests at 0x0,0x4,0x8 on consecutive cycles after the first response; if_id_pc steps 0x0,0x4,0x8 with if_id_valid=1 every cycle; if_id_pc4 = pc+4.
- stall=1 for 3 cycles when the response for 0x8 arrives: IF/ID holds 0x4 for 3 cycles, no imem_req during HOLD; after release if_id_pc=0x8 with correct inst, then ISSUE at 0xC.
- redirect=1, redirect_pc=0x100 while the 0x10 request is outstanding with 3-cycle latency: if_id_valid=0 and if_id_inst=0x00000013 next cycle; the 0x10 response is discarded; next imem_addr=0x100; if_id_pc=0x100.
- redirect and stall both high in one cycle: bubble is loaded (flush wins); the next fetch is at redirect_pc.
- redirect_pc=0x203: fetch address is 0x200.
- PC wrap: RESET_PC=0xFFFF_FFF8 gives fetches at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Async reset mid-WAIT with a late rvalid: outputs return to reset values immediately; the late response is ignored; first fetch after release is at RESET_PC.
